// File: rtl/mil_txd_enc.sv
// MIL-STD-1553 style Manchester word transmitter: 3-bit-time sync, 16 data bits MSB first,
// odd parity bit. Line drives are registered and derived from the next-state view of the datapath.
module mil_txd_enc #(
   parameter int Fclk  = 50000000,
   parameter int TXvel = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        CW_DW,
   input  logic [15:0] din,
   output logic        TX_P,
   output logic        TX_N,
   output logic        busy,
   output logic        done,
   output logic [5:0]  cb_tact,
   output logic [4:0]  cb_bit
);

   localparam int T_BIT  = Fclk / TXvel;
   localparam int T_HALF = T_BIT / 2;
   localparam int T_SYH  = (3 * T_BIT) / 2;
   localparam int SW     = $clog2(2 * T_SYH);

   localparam logic [5:0]    TACT_LAST = 6'(T_BIT - 1);
   localparam logic [5:0]    TACT_HALF = 6'(T_HALF);
   localparam logic [4:0]    BIT_LAST  = 5'd15;
   localparam logic [SW-1:0] SYNC_LAST = SW'(2 * T_SYH - 1);
   localparam logic [SW-1:0] SYNC_HALF = SW'(T_SYH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2,
      PAR  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   sync_cnt_q, sync_cnt_d;
   logic [5:0]      cb_tact_q, cb_tact_d;
   logic [4:0]      cb_bit_q, cb_bit_d;
   logic [15:0]     sr_q, sr_d;
   logic            cw_q, cw_d;
   logic            par_q, par_d;
   logic            tx_p_q, tx_p_d;
   logic            tx_n_q, tx_n_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            bit_wrap;
   logic            drive;
   logic            line_level;

   // Sequencing: state, counters, shift register and parity accumulator.
   always_comb begin
      state_d    = state_q;
      sync_cnt_d = sync_cnt_q;
      cb_tact_d  = cb_tact_q;
      cb_bit_d   = cb_bit_q;
      sr_d       = sr_q;
      cw_d       = cw_q;
      par_d      = par_q;
      done_d     = 1'b0;
      bit_wrap   = (cb_tact_q == TACT_LAST);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SYNC;
               sync_cnt_d = '0;
               cb_tact_d  = '0;
               cb_bit_d   = '0;
               sr_d       = din;
               cw_d       = CW_DW;
               par_d      = 1'b0;
            end
         end
         SYNC: begin
            if (sync_cnt_q == SYNC_LAST) begin
               state_d    = DATA;
               sync_cnt_d = '0;
            end else begin
               sync_cnt_d = sync_cnt_q + SW'(1);
            end
         end
         DATA: begin
            if (bit_wrap) begin
               cb_tact_d = '0;
               cb_bit_d  = cb_bit_q + 5'd1;
               par_d     = par_q ^ sr_q[15];
               sr_d      = {sr_q[14:0], 1'b0};
               if (cb_bit_q == BIT_LAST) begin
                  state_d = PAR;
               end
            end else begin
               cb_tact_d = cb_tact_q + 6'd1;
            end
         end
         PAR: begin
            if (bit_wrap) begin
               state_d   = IDLE;
               cb_tact_d = '0;
               cb_bit_d  = '0;
               done_d    = 1'b1;
            end else begin
               cb_tact_d = cb_tact_q + 6'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Line encoder works on next-state values so the registered lines line up with the state.
   // line_level = 1 means TX_P driven, 0 means TX_N driven; first half of a bit carries the bit.
   always_comb begin
      drive      = 1'b0;
      line_level = 1'b0;
      case (state_d)
         SYNC: begin
            drive      = 1'b1;
            line_level = (sync_cnt_d < SYNC_HALF) ? cw_d : ~cw_d;
         end
         DATA: begin
            drive      = 1'b1;
            line_level = (cb_tact_d < TACT_HALF) ? sr_d[15] : ~sr_d[15];
         end
         PAR: begin
            drive      = 1'b1;
            line_level = (cb_tact_d < TACT_HALF) ? ~par_d : par_d;
         end
         default: begin
            drive      = 1'b0;
            line_level = 1'b0;
         end
      endcase
      tx_p_d = drive & line_level;
      tx_n_d = drive & ~line_level;
      busy_d = drive;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sync_cnt_q <= '0;
         cb_tact_q  <= '0;
         cb_bit_q   <= '0;
         sr_q       <= '0;
         cw_q       <= 1'b0;
         par_q      <= 1'b0;
         tx_p_q     <= 1'b0;
         tx_n_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_cnt_q <= sync_cnt_d;
         cb_tact_q  <= cb_tact_d;
         cb_bit_q   <= cb_bit_d;
         sr_q       <= sr_d;
         cw_q       <= cw_d;
         par_q      <= par_d;
         tx_p_q     <= tx_p_d;
         tx_n_q     <= tx_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign TX_P    = tx_p_q;
   assign TX_N    = tx_n_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign cb_tact = cb_tact_q;
   assign cb_bit  = cb_bit_q;

endmodule

// File: tb/tb_mil_txd_enc.sv
// Bench for mil_txd_enc: expected line waveform per word is built from the Manchester/sync rules,
// then compared cycle by cycle while inputs are scrambled and stray starts are injected.
module tb_mil_txd_enc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        CW_DW;
   logic [15:0] din;
   logic        TX_P, TX_N, busy, done;
   logic [5:0]  cb_tact;
   logic [4:0]  cb_bit;

   int vectors = 0;
   int miscompares = 0;

   logic exp_lvl [0:999];

   mil_txd_enc #(.Fclk(50000000), .TXvel(1000000)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .CW_DW   (CW_DW),
      .din     (din),
      .TX_P    (TX_P),
      .TX_N    (TX_N),
      .busy    (busy),
      .done    (done),
      .cb_tact (cb_tact),
      .cb_bit  (cb_bit)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference word: level 1 = TX_P driven, 0 = TX_N driven, one entry per drive cycle.
   task automatic build(input logic cw, input logic [15:0] d);
      int   k = 0;
      logic p;
      for (int i = 0; i < 75; i++) begin exp_lvl[k] = cw;  k++; end
      for (int i = 0; i < 75; i++) begin exp_lvl[k] = !cw; k++; end
      for (int b = 15; b >= 0; b--) begin
         for (int i = 0; i < 25; i++) begin exp_lvl[k] = d[b];  k++; end
         for (int i = 0; i < 25; i++) begin exp_lvl[k] = !d[b]; k++; end
      end
      p = ~(^d);
      for (int i = 0; i < 25; i++) begin exp_lvl[k] = p;  k++; end
      for (int i = 0; i < 25; i++) begin exp_lvl[k] = !p; k++; end
   endtask

   task automatic check_idle(input string tag, input logic exp_done);
      chk({tag, "_tx_p"}, TX_P, 0);
      chk({tag, "_tx_n"}, TX_N, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_cb_tact"}, cb_tact, 0);
      chk({tag, "_cb_bit"}, cb_bit, 0);
   endtask

   // Expects start/din/CW_DW already presented for the accepting edge.
   task automatic run_word(input logic cw, input logic [15:0] d, input int abort_k,
                           input bit chain, input logic cw2, input logic [15:0] d2);
      bit   aborted = 0;
      logic lv;
      build(cw, d);
      tick();
      for (int k = 0; k < 1000 && !aborted; k++) begin
         lv = exp_lvl[k];
         chk("tx_p", TX_P, lv);
         chk("tx_n", TX_N, !lv);
         chk("no_overlap", TX_P & TX_N, 0);
         chk("busy", busy, 1);
         chk("done_early", done, 0);
         chk("cb_tact", cb_tact, (k < 150) ? 0 : (k - 150) % 50);
         chk("cb_bit", cb_bit, (k < 150) ? 0 : (k - 150) / 50);
         if (k == abort_k) begin
            rst_n   = 1'b0;
            start   = 1'b1;
            aborted = 1;
         end else begin
            start = (k == 500) || (k < 999 && $urandom_range(0, 15) == 0);
            din   = 16'($urandom);
            CW_DW = 1'($urandom);
            if (k == 999) begin
               start = chain;
               din   = d2;
               CW_DW = cw2;
            end
         end
         tick();
      end
      if (aborted) begin
         check_idle("abort", 1'b0);
         tick();
         check_idle("abort_hold", 1'b0);
         rst_n = 1'b1;
         start = 1'b0;
         for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("abort_after", 1'b0);
         end
      end else begin
         check_idle("done_cycle", 1'b1);
         if (!chain) begin
            tick();
            check_idle("post_done", 1'b0);
         end
      end
   endtask

   task automatic launch(input logic cw, input logic [15:0] d, input bit chain,
                         input logic cw2, input logic [15:0] d2);
      start = 1'b1;
      CW_DW = cw;
      din   = d;
      run_word(cw, d, -1, chain, cw2, d2);
   endtask

   logic [15:0] w_cur, w_nxt;
   logic        c_cur, c_nxt;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      CW_DW = 1'b0;
      din   = 16'h0000;
      tick();
      tick();
      check_idle("reset", 1'b0);
      rst_n = 1'b1;
      tick();
      check_idle("idle", 1'b0);

      launch(1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000);
      launch(1'b0, 16'h0001, 1'b0, 1'b0, 16'h0000);

      // Back-to-back: start held through done, next word starts after the done cycle.
      launch(1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
      run_word(1'b0, 16'h0000, -1, 1'b0, 1'b0, 16'h0000);

      c_cur = 1'($urandom);
      w_cur = 16'($urandom);
      start = 1'b1;
      CW_DW = c_cur;
      din   = w_cur;
      for (int n = 0; n < 6; n++) begin
         c_nxt = 1'($urandom);
         w_nxt = 16'($urandom);
         run_word(c_cur, w_cur, -1, (n < 5), c_nxt, w_nxt);
         c_cur = c_nxt;
         w_cur = w_nxt;
      end

      start = 1'b1;
      CW_DW = 1'b1;
      din   = 16'($urandom);
      run_word(1'b1, din, 300, 1'b0, 1'b0, 16'h0000);

      launch(1'b0, 16'h8000, 1'b0, 1'b0, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
